// File: rtl/audio_pkg.sv
// Shared types and defaults for the audio record/playback controllers.
package audio_pkg;

    localparam int unsigned REC_BITLEN_DEF = 16;
    localparam int unsigned ADDR_W_DEF     = 20;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_REC   = 3'd2,
        S_WRITE = 3'd3,
        S_PAUSE = 3'd4,
        S_DONE  = 3'd5
    } rec_state_t;

endpackage

// File: rtl/audio_rec_ctrl_if.sv
// SRAM write port: request/address/data held until ack.
interface audio_rec_ctrl_if #(
    parameter int unsigned AW = 20,
    parameter int unsigned DW = 16
) ();

    logic          req;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;

    modport master (output req, output addr, output wdata, input ack);
    modport slave  (input req, input addr, input wdata, output ack);

endinterface

// File: rtl/lrck_edge_det.sv
// Registers LRCK and produces single-cycle rise/fall pulses.
module lrck_edge_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_lrck,
    output logic o_rise,
    output logic o_fall
);

    logic lrck_q;

    // Reset high so a line already high after reset is not taken as a rise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lrck_q <= 1'b1;
        end else begin
            lrck_q <= i_lrck;
        end
    end

    assign o_rise = i_lrck & ~lrck_q;
    assign o_fall = ~i_lrck & lrck_q;

endmodule

// File: rtl/audio_rec_ctrl.sv
// Recording controller: captures left ADC samples on LRCK rise and writes them to SRAM.
module audio_rec_ctrl
    import audio_pkg::*;
#(
    parameter int unsigned REC_BITLEN  = REC_BITLEN_DEF,
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned MAX_SAMPLES = 1048576
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic                   i_pause,
    input  logic                   i_stop,
    input  logic                   i_adclrck,
    input  logic [REC_BITLEN-1:0]  i_adc_data,
    audio_rec_ctrl_if.master       sram,
    output logic [2:0]             o_state,
    output logic [ADDR_W:0]        o_rec_len,
    output logic                   o_full,
    output logic                   o_overrun
);

    localparam logic [ADDR_W:0] MaxLen = (ADDR_W + 1)'(MAX_SAMPLES);

    rec_state_t             state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [ADDR_W:0]        len_q, len_d;
    logic [REC_BITLEN-1:0]  sample_q, sample_d;
    logic                   full_q, full_d;
    logic                   ovr_q, ovr_d;
    logic                   stop_pend_q, stop_pend_d;
    logic                   pause_pend_q, pause_pend_d;
    logic                   lrck_rise;
    logic                   lrck_fall_unused;
    logic                   stop_any, pause_any;

    lrck_edge_det u_lrck_edge_det (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_lrck  (i_adclrck),
        .o_rise  (lrck_rise),
        .o_fall  (lrck_fall_unused)
    );

    // Commands seen while a write is in flight are folded in at ack time.
    assign stop_any  = stop_pend_q | i_stop;
    assign pause_any = pause_pend_q | i_pause;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        sample_d     = sample_q;
        full_d       = full_q;
        ovr_d        = ovr_q;
        stop_pend_d  = stop_pend_q;
        pause_pend_d = pause_pend_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    addr_d  = '0;
                    len_d   = '0;
                    full_d  = 1'b0;
                    ovr_d   = 1'b0;
                    state_d = S_ARM;
                end
            end
            S_ARM, S_REC: begin
                if (i_stop) begin
                    state_d = (state_q == S_ARM) ? S_IDLE : S_DONE;
                end else if (i_pause) begin
                    state_d = S_PAUSE;
                end else if (lrck_rise) begin
                    sample_d = i_adc_data;
                    state_d  = S_WRITE;
                end
            end
            S_WRITE: begin
                if (lrck_rise) ovr_d = 1'b1;
                stop_pend_d  = stop_any;
                pause_pend_d = pause_any;
                if (sram.ack) begin
                    addr_d       = addr_q + 1'b1;
                    len_d        = len_q + 1'b1;
                    stop_pend_d  = 1'b0;
                    pause_pend_d = 1'b0;
                    if (len_d == MaxLen) begin
                        full_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (stop_any) begin
                        state_d = S_DONE;
                    end else if (pause_any) begin
                        state_d = S_PAUSE;
                    end else begin
                        state_d = S_REC;
                    end
                end
            end
            S_PAUSE: begin
                if (i_stop) begin
                    state_d = S_DONE;
                end else if (i_start) begin
                    state_d = S_ARM;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            sample_q     <= '0;
            full_q       <= 1'b0;
            ovr_q        <= 1'b0;
            stop_pend_q  <= 1'b0;
            pause_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            sample_q     <= sample_d;
            full_q       <= full_d;
            ovr_q        <= ovr_d;
            stop_pend_q  <= stop_pend_d;
            pause_pend_q <= pause_pend_d;
        end
    end

    // Request decoded straight from state so reset drops it without waiting for a clock.
    assign sram.req   = (state_q == S_WRITE);
    assign sram.addr  = addr_q;
    assign sram.wdata = sample_q;
    assign o_state    = state_q;
    assign o_rec_len  = len_q;
    assign o_full     = full_q;
    assign o_overrun  = ovr_q;

endmodule

// File: tb/tb_audio_rec_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a reference model.
module tb_audio_rec_ctrl;
    import audio_pkg::*;

    localparam int unsigned BL  = 16;
    localparam int unsigned AW  = 4;
    localparam int unsigned MAX = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, pause, stop, lrck;
    logic [BL-1:0] adc_data;
    logic [2:0]    dut_state;
    logic [AW:0]   dut_len;
    logic          dut_full, dut_ovr;

    audio_rec_ctrl_if #(.AW(AW), .DW(BL)) sram_if ();

    audio_rec_ctrl #(.REC_BITLEN(BL), .ADDR_W(AW), .MAX_SAMPLES(MAX)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_pause    (pause),
        .i_stop     (stop),
        .i_adclrck  (lrck),
        .i_adc_data (adc_data),
        .sram       (sram_if),
        .o_state    (dut_state),
        .o_rec_len  (dut_len),
        .o_full     (dut_full),
        .o_overrun  (dut_ovr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: recording status tracked as plain counters.
    rec_state_t    m_st;
    int            m_addr, m_len;
    bit            m_full, m_ovr, m_lrprev, m_pstop, m_ppause;
    logic [BL-1:0] m_sample;

    int            ack_dly;
    int            wcnt;
    bit            cur_lr;
    logic [31:0]   wr_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = S_IDLE; m_addr = 0; m_len = 0; m_full = 0; m_ovr = 0;
        m_lrprev = 1; m_pstop = 0; m_ppause = 0; m_sample = '0; wcnt = 0;
    endtask

    task automatic model_step(input bit st, pa, sp, lr, input logic [BL-1:0] d, input bit ak);
        bit rise;
        rise = lr && !m_lrprev;
        m_lrprev = lr;
        case (m_st)
            S_IDLE, S_DONE: if (st) begin
                m_addr = 0; m_len = 0; m_full = 0; m_ovr = 0; m_st = S_ARM;
            end
            S_ARM, S_REC: begin
                if (sp) m_st = (m_st == S_ARM) ? S_IDLE : S_DONE;
                else if (pa) m_st = S_PAUSE;
                else if (rise) begin m_sample = d; m_st = S_WRITE; end
            end
            S_WRITE: begin
                if (rise) m_ovr = 1;
                m_pstop  = m_pstop | sp;
                m_ppause = m_ppause | pa;
                if (ak) begin
                    m_addr++; m_len++;
                    if (m_len == MAX) begin m_full = 1; m_st = S_DONE; end
                    else if (m_pstop) m_st = S_DONE;
                    else if (m_ppause) m_st = S_PAUSE;
                    else m_st = S_REC;
                    m_pstop = 0; m_ppause = 0;
                end
            end
            S_PAUSE: begin
                if (sp) m_st = S_DONE;
                else if (st) m_st = S_ARM;
            end
            default: m_st = S_IDLE;
        endcase
    endtask

    task automatic compare_all();
        check("state", 32'(dut_state), 32'(m_st));
        check("req", 32'(sram_if.req), 32'(m_st == S_WRITE));
        check("addr", 32'(sram_if.addr), 32'(m_addr % (1 << AW)));
        check("wdata", 32'(sram_if.wdata), 32'(m_sample));
        check("len", 32'(dut_len), 32'(m_len));
        check("full", 32'(dut_full), 32'(m_full));
        check("overrun", 32'(dut_ovr), 32'(m_ovr));
    endtask

    task automatic step(input bit st, pa, sp, lr, input logic [BL-1:0] d);
        bit ak;
        rec_state_t prev;
        ak = (m_st == S_WRITE) && (wcnt == 0);
        if (m_st == S_WRITE && wcnt > 0) wcnt--;
        if (ack_dly < 0 && m_st != S_WRITE) ak = ($urandom_range(0, 3) == 0);
        start = st; pause = pa; stop = sp; lrck = lr; adc_data = d; sram_if.ack = ak;
        if (sram_if.req && ak) wr_q.push_back({12'(sram_if.addr), 4'h0, sram_if.wdata});
        prev = m_st;
        model_step(st, pa, sp, lr, d, ak);
        if (m_st == S_WRITE && prev != S_WRITE)
            wcnt = (ack_dly < 0) ? int'($urandom_range(0, 9)) : ack_dly;
        cur_lr = lr;
        @(negedge clk);
        compare_all();
    endtask

    task automatic cmd(input bit st, pa, sp);
        step(st, pa, sp, cur_lr, BL'($urandom));
    endtask

    task automatic frame(input logic [BL-1:0] d);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, BL'($urandom));
        step(0, 0, 0, 1, d);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, BL'($urandom));
    endtask

    initial begin
        logic [BL-1:0] smp [4];
        logic [BL-1:0] a, c, z;
        int            half, lcnt, r, nwr;
        smp[0] = 16'h1234; smp[1] = 16'hABCD; smp[2] = 16'h0001; smp[3] = 16'hFFFF;

        rst_n = 0; start = 0; pause = 0; stop = 0; lrck = 0; adc_data = '0;
        sram_if.ack = 0; cur_lr = 0; ack_dly = 0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1;

        // Basic capture with immediate ack.
        cmd(1, 0, 0);
        wr_q.delete();
        for (int i = 0; i < 4; i++) frame(smp[i]);
        check("basic_len", 32'(dut_len), 32'd4);
        check("basic_state", 32'(dut_state), 32'(S_REC));
        check("basic_nwr", 32'(wr_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < wr_q.size(); i++)
            check("basic_wr", wr_q[i], {12'(i), 4'h0, smp[i]});

        // Overrun: ack withheld across the next LRCK rise.
        cmd(0, 0, 1);
        cmd(1, 0, 0);
        wr_q.delete();
        ack_dly = 12;
        a = BL'($urandom);
        c = BL'($urandom);
        frame(a);
        ack_dly = 0;
        frame(BL'($urandom));
        frame(c);
        check("ovr_flag", 32'(dut_ovr), 32'd1);
        check("ovr_len", 32'(dut_len), 32'd2);
        check("ovr_nwr", 32'(wr_q.size()), 32'd2);
        if (wr_q.size() == 2) check("ovr_next", wr_q[1], {12'd1, 4'h0, c});

        // Pause / resume keeps the address.
        cmd(0, 0, 1);
        cmd(1, 0, 0);
        frame(BL'($urandom));
        frame(BL'($urandom));
        cmd(0, 1, 0);
        check("pause_state", 32'(dut_state), 32'(S_PAUSE));
        for (int i = 0; i < 3; i++) frame(BL'($urandom));
        cmd(1, 0, 0);
        wr_q.delete();
        a = BL'($urandom);
        frame(a);
        check("resume_nwr", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() == 1) check("resume_wr", wr_q[0], {12'd2, 4'h0, a});
        cmd(0, 0, 1);
        check("stop_state", 32'(dut_state), 32'(S_DONE));
        check("stop_len", 32'(dut_len), 32'd3);

        // Start+stop together in S_REC; then stop during a slow write.
        cmd(1, 0, 0);
        frame(BL'($urandom));
        cmd(1, 0, 1);
        check("simul_state", 32'(dut_state), 32'(S_DONE));
        cmd(1, 0, 0);
        ack_dly = 6;
        frame(BL'($urandom));
        cmd(0, 0, 1);
        check("wr_hold", 32'(sram_if.req), 32'd1);
        repeat (4) cmd(0, 0, 0);
        check("wstop_state", 32'(dut_state), 32'(S_DONE));
        check("wstop_len", 32'(dut_len), 32'd1);

        // Fill to capacity with a 3-cycle ack.
        cmd(1, 0, 0);
        ack_dly = 3;
        for (int i = 0; i < MAX + 1; i++) frame(BL'($urandom));
        check("full_flag", 32'(dut_full), 32'd1);
        check("full_state", 32'(dut_state), 32'(S_DONE));
        check("full_len", 32'(dut_len), 32'(MAX));

        // Asynchronous reset in the middle of a write.
        ack_dly = 0;
        cmd(1, 0, 0);
        frame(BL'($urandom));
        ack_dly = 20;
        frame(BL'($urandom));
        #2 rst_n = 0;
        #1;
        check("rst_req", 32'(sram_if.req), 32'd0);
        check("rst_state", 32'(dut_state), 32'(S_IDLE));
        check("rst_len", 32'(dut_len), 32'd0);
        model_reset();
        @(negedge clk);
        compare_all();
        rst_n = 1;
        ack_dly = 0;
        cmd(1, 0, 0);
        wr_q.delete();
        z = BL'($urandom);
        frame(z);
        nwr = wr_q.size();
        check("rst_nwr", 32'(nwr), 32'd1);
        if (nwr == 1) check("rst_wr", wr_q[0], {12'd0, 4'h0, z});

        // Random traffic.
        ack_dly = -1;
        half = 3;
        lcnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit st, pa, sp, lr;
            lr = cur_lr;
            if (++lcnt >= half) begin
                lr = !cur_lr;
                lcnt = 0;
                half = $urandom_range(2, 5);
            end
            r = $urandom_range(0, 99);
            if (m_st == S_IDLE || m_st == S_DONE) begin
                st = (r < 15); pa = (r == 50); sp = (r == 51);
            end else begin
                st = (r < 2) || (r == 5);
                pa = (r == 2) || (r == 3) || (r == 5);
                sp = (r == 4) || (r == 5);
            end
            step(st, pa, sp, lr, BL'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
